load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit words in the downstream data memory (valid byte range 0 .. 4*MEM_WORDS-1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data; the value sits in the low bits for B/H.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_err  output  1  qualifies resp_valid: misaligned, out-of-range or illegal funct3.
REQ-012 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 SHALL have port mem_read  output  1  read enable to the data memory.
REQ-014 SHALL have port mem_write  output  1  write enable to the data memory; the write is committed at the clk edge ending the cycle.
REQ-015 SHALL have port mem_addr  output  32  word-aligned address: latched address with bits [1:0] forced to 00.
REQ-016 SHALL have port mem_wdata  output  32  full word to write.
REQ-017 SHALL have port mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 SHALL implement the states IDLE, LOAD, RMW_RD, WRITE, RESP and ERR.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted when req_valid=1 and req_ready=1, and all req_* fields are latched on that edge.
REQ-020 SHALL route an accepted request to ERR for any of these conditions: funct3 not in the legal set (stores: 000/001/010 only); H/HU with addr[0]=1; W with addr[1:0]!=00; addr >= 4*MEM_WORDS.
REQ-021 SHALL route other requests as follows: load -> LOAD; SW -> WRITE with merge word = wdata; SB/SH -> RMW_RD.
REQ-022 SHALL, in LOAD, assert mem_read and extract the byte/half selected by addr[1:0] from mem_rdata, sign-extending for B/H and zero-extending for BU/HU, then register the result into resp_rdata and go to RESP.
REQ-023 SHALL, in RMW_RD, assert mem_read and register mem_rdata with the selected byte lane (SB: wdata[7:0]) or half lane (SH: wdata[15:0]) replaced; all other lanes are left unchanged; then go to WRITE.
REQ-024 SHALL, in WRITE, assert mem_write with mem_wdata = the merge word, then go to RESP.
REQ-025 SHALL, in RESP, assert resp_valid=1 with resp_err=0 for exactly one cycle, then return to IDLE.
REQ-026 SHALL, in ERR, assert resp_valid=1 and resp_err=1 for one cycle with no memory access and resp_rdata=0, then return to IDLE.
REQ-027 SHALL meet these latencies, counted from the acceptance edge to the cycle in which resp_valid=1: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-028 SHALL never assert mem_read and mem_write in the same cycle, and SHALL assert neither outside LOAD, RMW_RD and WRITE.
REQ-029 SHALL ignore req_valid in every state other than IDLE; a request held high during a busy period is accepted on the first IDLE cycle.
REQ-030 SHALL hold resp_rdata until the next response and SHALL clear it to 0 on a store response.
REQ-031 SHALL accept a new request on the IDLE cycle after RESP/ERR, giving back-to-back throughput of one request per 3 cycles for loads and SW and one per 4 cycles for SB/SH.

Reset
REQ-032 SHALL, while rst_n=0, force req_ready, resp_valid, resp_err, mem_read and mem_write to 0 combinationally; a reset in WRITE therefore commits no write.
REQ-033 SHALL, on any edge with rst_n=0, set the state to IDLE, resp_rdata to 0 and the merge register to 0; an in-flight request is dropped with no response.
REQ-034 SHALL assert req_ready=1 on the first cycle after rst_n returns to 1.

Verification
REQ-035 SHALL cover this scenario: preload word 2 = 0x8765_43A1; LB at 0x008 -> resp_rdata=0xFFFF_FFA1 two cycles after acceptance; LBU at 0x008 -> 0x0000_00A1; LH at 0x00A -> 0xFFFF_8765.
REQ-036 SHALL cover this scenario: word 2 = 0x1122_3344; SB wdata=0xAB at 0x009 -> mem_read cycle, then mem_write cycle with mem_wdata=0x1122_AB44, resp_valid three cycles after acceptance.
REQ-037 SHALL cover this scenario: SW 0xDEAD_BEEF at 0x3FC with MEM_WORDS=256 -> a single mem_write cycle, mem_addr=0x3FC, resp_err=0; LW at 0x400 -> resp_err=1 one cycle after acceptance, with no mem_read or mem_write at any time.
REQ-038 SHALL cover this scenario: LH at 0x005, SW at 0x002, and funct3=011 -> each gives resp_err=1, resp_rdata=0, and memory unchanged.
REQ-039 SHALL cover this scenario: rst_n=0 asserted during the WRITE cycle of an SH -> mem_write=0 in that cycle, target word unchanged, no resp_valid, req_ready=1 on the first cycle after rst_n=1.
REQ-040 SHALL cover this scenario: req_valid held high with alternating LW/SB for 8 requests -> acceptances spaced 3/4 cycles apart, exactly one resp_valid per request, in request order.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer sitting between the core and
// a single-ported word-wide data memory. Sub-word stores are done as
// read-modify-write. Illegal width codes, misaligned accesses and
// out-of-range addresses complete with resp_err and never touch memory.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we, req_funct3      store flag and RV32I width code
//   req_addr, req_wdata     byte address and store data (low-aligned)
//   resp_valid/resp_err     one-cycle completion pulse and its error flag
//   resp_rdata              extended load data, 0 for stores and errors
//   mem_read/mem_write      memory enables (never both at once)
//   mem_addr, mem_wdata     word address and full write word
//   mem_rdata               combinational read data
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // one past the last legal byte address, widened so 4*MEM_WORDS cannot wrap
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  logic [2:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  // request legality, evaluated on the incoming request fields
  logic f3_ok, misal, oor, req_bad;
  always_comb begin
    f3_ok = 1'b0;
    misal = 1'b0;
    case (req_funct3)
      3'b000: f3_ok = 1'b1;
      3'b001: begin f3_ok = 1'b1;     misal = req_addr[0];          end
      3'b010: begin f3_ok = 1'b1;     misal = (req_addr[1:0] != 2'b00); end
      3'b100: f3_ok = !req_we;
      3'b101: begin f3_ok = !req_we;  misal = req_addr[0];          end
      default: f3_ok = 1'b0;
    endcase
    oor     = ({1'b0, req_addr} >= ADDR_LIMIT);
    req_bad = !f3_ok || misal || oor;
  end

  // load extraction: bring the addressed lane down to bit 0, then extend
  logic [31:0] shifted, load_val;
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // sub-word store merge: funct3[0] picks half vs byte lane width
  logic [31:0] lane_mask, lane_data, merged;
  always_comb begin
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {addr_q[1:0], 3'b000};
    lane_data = wdata_q << {addr_q[1:0], 3'b000};
    merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (req_bad) begin
            state      <= S_ERR;
            resp_rdata <= 32'h0;
          end else if (!req_we) begin
            state <= S_LOAD;
          end else if (req_funct3 == 3'b010) begin
            state   <= S_WRITE;
            merge_q <= req_wdata;
          end else begin
            state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          resp_rdata <= load_val;
          state      <= S_RESP;
        end
        S_RMW_RD: begin
          merge_q <= merged;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          resp_rdata <= 32'h0;
          state      <= S_RESP;
        end
        default: state <= S_IDLE;  // RESP, ERR and unused encodings
      endcase
    end
  end

  // control outputs are decoded from state and squashed while reset is low,
  // so a reset landing in WRITE suppresses the write in that same cycle
  assign req_ready  = rst_n && (state == S_IDLE);
  assign resp_valid = rst_n && ((state == S_RESP) || (state == S_ERR));
  assign resp_err   = rst_n && (state == S_ERR);
  assign mem_read   = rst_n && ((state == S_LOAD) || (state == S_RMW_RD));
  assign mem_write  = rst_n && (state == S_WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = merge_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule
